sprite_blitter: RTL

Parametrised pixel-stream generator that draws one rectangular primitive per command onto the VGA adapter's pixel-write port. Three modes: sprite blit from a frame-indexed sprite ROM with colour-key transparency, solid rectangle fill, and full-screen clear. Every pixel is screen-clipped. A start/busy/done handshake connects it to the game control FSM. It replaces the separate per-purpose draw counters (clear, background tile, sprite) with one engine that has fixed, predictable timing.

---
 rtl/sprite_blitter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/sprite_blitter.sv
// Sprite blit / rectangle fill / screen clear pixel-stream engine.
// One primitive per command; every mode has the same pipeline timing.
module sprite_blitter #(
  parameter int SCREEN_W    = 320,
  parameter int SCREEN_H    = 240,
  parameter int X_W         = 9,
  parameter int Y_W         = 8,
  parameter int SPR_W       = 16,
  parameter int SPR_H       = 16,
  parameter int FRAMES      = 4,
  parameter int COLOUR_W    = 15,
  parameter int ROM_LATENCY = 1,
  parameter int TRANS_EN    = 1,
  parameter logic [COLOUR_W-1:0] TRANS_KEY = 15'h7C1F
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [1:0]            mode,
  input  logic [X_W-1:0]        x0,
  input  logic [Y_W-1:0]        y0,
  input  logic [$clog2(FRAMES)-1:0] frame,
  input  logic [COLOUR_W-1:0]   fill_colour,
  output logic                  busy,
  output logic                  done,
  output logic [$clog2(FRAMES*SPR_W*SPR_H)-1:0] rom_addr,
  input  logic [COLOUR_W-1:0]   rom_data,
  output logic [X_W-1:0]        pix_x,
  output logic [Y_W-1:0]        pix_y,
  output logic [COLOUR_W-1:0]   pix_colour,
  output logic                  pix_plot
);

  localparam int FW     = $clog2(FRAMES);
  localparam int AW     = $clog2(FRAMES*SPR_W*SPR_H);
  localparam int PIX_SH = $clog2(SPR_W*SPR_H);
  localparam int L      = ROM_LATENCY;

  localparam logic [1:0] M_BLIT  = 2'd0;
  localparam logic [1:0] M_CLEAR = 2'd2;
  localparam logic [1:0] M_NOP   = 2'd3;

  localparam logic [X_W:0] SW_L = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] SH_L = (Y_W+1)'(SCREEN_H);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t               state;
  logic [1:0]           mode_r;
  logic [X_W-1:0]       x0_r;
  logic [Y_W-1:0]       y0_r;
  logic [FW-1:0]        frame_r;
  logic [COLOUR_W-1:0]  colour_r;
  logic [X_W-1:0]       i;
  logic [Y_W-1:0]       j;
  logic [7:0]           dcnt;

  logic [X_W-1:0]       w_last;
  logic [Y_W-1:0]       h_last;
  logic [X_W-1:0]       i_nx;
  logic [Y_W-1:0]       j_nx;
  logic [X_W:0]         sx;
  logic [Y_W:0]         sy;
  logic                 in_scr;
  logic                 px_last;
  logic                 key_hit;
  logic                 plot_nx;
  logic                 kill;

  // Coordinate pipeline, aligned with the ROM read latency
  logic                 pv  [L];
  logic                 pin [L];
  logic [X_W-1:0]       pxx [L];
  logic [Y_W-1:0]       pyy [L];

  function automatic logic [AW-1:0] addr_of(
    input logic [FW-1:0]  f,
    input logic [X_W-1:0] ii,
    input logic [Y_W-1:0] jj
  );
    return (AW'(f) << PIX_SH) + AW'(jj) * AW'(SPR_W) + AW'(ii);
  endfunction

  always_comb begin
    w_last  = (mode_r == M_CLEAR) ? X_W'(SCREEN_W-1) : X_W'(SPR_W-1);
    h_last  = (mode_r == M_CLEAR) ? Y_W'(SCREEN_H-1) : Y_W'(SPR_H-1);
    px_last = (i == w_last) && (j == h_last);
    i_nx    = (i == w_last) ? '0 : i + 1'b1;
    j_nx    = (i == w_last) ? j + 1'b1 : j;
    sx      = {1'b0, x0_r} + {1'b0, i};
    sy      = {1'b0, y0_r} + {1'b0, j};
    in_scr  = (sx < SW_L) && (sy < SH_L);
    key_hit = (TRANS_EN != 0) && (mode_r == M_BLIT) &&
              (rom_data == TRANS_KEY);
    plot_nx = pv[L-1] && pin[L-1] && !key_hit;
    kill    = abort && (state == RUN || state == DRAIN);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      pix_plot   <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_colour <= '0;
      rom_addr   <= '0;
      mode_r     <= '0;
      x0_r       <= '0;
      y0_r       <= '0;
      frame_r    <= '0;
      colour_r   <= '0;
      i          <= '0;
      j          <= '0;
      dcnt       <= '0;
      for (int k = 0; k < L; k++) begin
        pv[k]  <= 1'b0;
        pin[k] <= 1'b0;
        pxx[k] <= '0;
        pyy[k] <= '0;
      end
    end else begin
      done   <= 1'b0;
      pv[0]  <= (state == RUN) && !kill;
      pin[0] <= in_scr;
      pxx[0] <= sx[X_W-1:0];
      pyy[0] <= sy[Y_W-1:0];
      for (int k = 1; k < L; k++) begin
        pv[k]  <= pv[k-1] && !kill;
        pin[k] <= pin[k-1];
        pxx[k] <= pxx[k-1];
        pyy[k] <= pyy[k-1];
      end
      pix_plot <= plot_nx && !kill;
      if (pv[L-1]) begin
        pix_x      <= pxx[L-1];
        pix_y      <= pyy[L-1];
        pix_colour <= (mode_r == M_BLIT) ? rom_data : colour_r;
      end
      unique case (state)
        IDLE: if (start) begin
          mode_r   <= mode;
          x0_r     <= (mode == M_CLEAR) ? '0 : x0;
          y0_r     <= (mode == M_CLEAR) ? '0 : y0;
          frame_r  <= frame;
          colour_r <= fill_colour;
          i        <= '0;
          j        <= '0;
          dcnt     <= '0;
          rom_addr <= addr_of(frame, '0, '0);
          state    <= (mode == M_NOP) ? DONE : RUN;
          busy     <= (mode != M_NOP);
          done     <= (mode == M_NOP);
        end
        RUN: if (kill) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else if (px_last) begin
          state <= DRAIN;
        end else begin
          i        <= i_nx;
          j        <= j_nx;
          rom_addr <= addr_of(frame_r, i_nx, j_nx);
        end
        DRAIN: if (kill) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else if (dcnt == 8'(L)) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          dcnt <= dcnt + 1'b1;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
